// File: rtl/nes_pad_scanner_if.sv
// Host/pad signal bundle for nes_pad_scanner; the scanner connects through the slave modport.
interface nes_pad_scanner_if #(
  parameter int NUM_PADS = 2,
  parameter int BITS     = 8
);
  logic                     enable;
  logic                     poll_now;
  logic [NUM_PADS-1:0]      nes_data;
  logic [NUM_PADS-1:0]      nes_latch;
  logic [NUM_PADS-1:0]      nes_pulse;
  logic [NUM_PADS*BITS-1:0] buttons;
  logic [NUM_PADS-1:0]      connected;
  logic                     valid;
  logic                     busy;

  modport master (
    output enable, poll_now, nes_data,
    input  nes_latch, nes_pulse, buttons, connected, valid, busy
  );

  modport slave (
    input  enable, poll_now, nes_data,
    output nes_latch, nes_pulse, buttons, connected, valid, busy
  );
endinterface

// File: rtl/nes_pad_scanner.sv
// Lockstep serial scanner for NUM_PADS NES/SNES pads: drives latch/pulse, deserialises data,
// detects pad presence and polls periodically or on request.
module nes_pad_scanner #(
  parameter int NUM_PADS = 2,
  parameter int BITS     = 8,
  parameter int HALF_CYC = 600,
  parameter int POLL_DIV = 1666667
) (
  input  logic               sysclk,
  input  logic               sysreset,
  nes_pad_scanner_if.slave   bus
);

  localparam int HW = $clog2(2*HALF_CYC);
  localparam int BW = $clog2(BITS+1);
  localparam int TW = $clog2(POLL_DIV);

  localparam logic [HW-1:0] LATCH_LAST = HW'(2*HALF_CYC-1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_CYC-1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS-1);
  localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_DIV-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_PULSE_HI,
    S_PULSE_LO,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [NUM_PADS-1:0] data_meta;
  logic [NUM_PADS-1:0] data_sync;

  logic [TW-1:0]       poll_cnt;
  logic                trigger;
  logic                start;

  logic [HW-1:0]       half_cnt;
  logic                half_last;
  logic [BW-1:0]       bit_cnt;
  logic                bit_last;

  logic                sample_en;
  logic                publish;
  logic [BITS-1:0]     shreg [NUM_PADS];

  // Idle pad lines float high, so the synchroniser resets to the "absent" level.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      data_meta <= '1;
      data_sync <= '1;
    end else begin
      data_meta <= bus.nes_data;
      data_sync <= data_meta;
    end
  end

  assign trigger = bus.enable && (poll_cnt == POLL_LAST);
  assign start   = (state == S_IDLE) && (bus.poll_now || trigger);

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      poll_cnt <= '0;
    end else if (!bus.enable || start || trigger) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign half_last = (state == S_LATCH) ? (half_cnt == LATCH_LAST) : (half_cnt == HALF_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign sample_en = half_last && ((state == S_LATCH) || (state == S_PULSE_LO));
  assign publish   = half_last && bit_last && (state == S_PULSE_LO);

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start)     state_nxt = S_LATCH;
      S_LATCH:    if (half_last) state_nxt = S_PULSE_HI;
      S_PULSE_HI: if (half_last) state_nxt = S_PULSE_LO;
      S_PULSE_LO: if (half_last) state_nxt = bit_last ? S_DONE : S_PULSE_HI;
      S_DONE:                    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      unique case (state)
        S_LATCH, S_PULSE_HI, S_PULSE_LO: half_cnt <= half_last ? '0 : half_cnt + 1'b1;
        default:                         half_cnt <= '0;
      endcase
      if (state == S_IDLE) begin
        bit_cnt <= '0;
      end else if ((state == S_PULSE_LO) && half_last) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Samples enter at the MSB so sample i ends at bit i; the final (presence) sample
  // is taken straight from the synchroniser on the publishing edge.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        shreg[p] <= '0;
      end
      bus.buttons   <= '0;
      bus.connected <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        if (sample_en) begin
          shreg[p] <= {data_sync[p], shreg[p][BITS-1:1]};
        end
        if (publish) begin
          bus.buttons[p*BITS +: BITS] <= ~shreg[p];
          bus.connected[p]            <= ~data_sync[p];
        end
      end
    end
  end

  always_comb begin
    bus.nes_latch = '0;
    bus.nes_pulse = '0;
    bus.busy      = 1'b0;
    bus.valid     = 1'b0;
    unique case (state)
      S_LATCH: begin
        bus.nes_latch = '1;
        bus.busy      = 1'b1;
      end
      S_PULSE_HI: begin
        bus.nes_pulse = '1;
        bus.busy      = 1'b1;
      end
      S_PULSE_LO: bus.busy  = 1'b1;
      S_DONE:     bus.valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Bench for nes_pad_scanner: behavioural pad models, a frame-timing reference model and directed scenarios.
module tb_nes_pad_scanner;

  localparam int H   = 4;
  localparam int PD  = 200;
  localparam int NP  = 2;
  localparam int B8  = 8;
  localparam int B16 = 16;
  localparam int L8  = 2*H*(B8+1);

  logic sysclk   = 1'b0;
  logic sysreset = 1'b0;
  always #5 sysclk = ~sysclk;

  nes_pad_scanner_if #(.NUM_PADS(NP), .BITS(B8))  bus ();
  nes_pad_scanner_if #(.NUM_PADS(NP), .BITS(B16)) sbus ();

  nes_pad_scanner #(.NUM_PADS(NP), .BITS(B8), .HALF_CYC(H), .POLL_DIV(PD)) dut (
    .sysclk  (sysclk),
    .sysreset(sysreset),
    .bus     (bus)
  );

  nes_pad_scanner #(.NUM_PADS(NP), .BITS(B16), .HALF_CYC(H), .POLL_DIV(PD)) dut16 (
    .sysclk  (sysclk),
    .sysreset(sysreset),
    .bus     (sbus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pad models: a shift register of active-low buttons, low after the last button when present.
  logic [B8-1:0]  press8  [NP];
  logic [B16-1:0] press16 [NP];
  logic [NP-1:0]  present8  = '1;
  logic [NP-1:0]  present16 = '1;
  int             idx8  [NP];
  int             idx16 [NP];
  logic [NP-1:0]  pq8  = '0;
  logic [NP-1:0]  pq16 = '0;

  always @(posedge sysclk) begin
    for (int p = 0; p < NP; p++) begin
      if (bus.nes_latch[p])                      idx8[p] <= 0;
      else if (bus.nes_pulse[p] && !pq8[p])      idx8[p] <= idx8[p] + 1;
      if (sbus.nes_latch[p])                     idx16[p] <= 0;
      else if (sbus.nes_pulse[p] && !pq16[p])    idx16[p] <= idx16[p] + 1;
    end
    pq8  <= bus.nes_pulse;
    pq16 <= sbus.nes_pulse;
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      bus.nes_data[p]  = !present8[p]  ? 1'b1 : (idx8[p]  < B8  ? ~press8[p][idx8[p]]   : 1'b0);
      sbus.nes_data[p] = !present16[p] ? 1'b1 : (idx16[p] < B16 ? ~press16[p][idx16[p]] : 1'b0);
    end
  end

  // Reference model: frame start time plus offsets within the frame give all expected outputs.
  int          t0      = 0;
  bit          have    = 1'b0;
  int          timer   = 0;
  int          m_off   = 0;
  bit          m_idle, m_trig, m_start;
  logic        exp_latch = 1'b0, exp_pulse = 1'b0, exp_busy = 1'b0, exp_valid = 1'b0;
  logic [15:0] exp_btn  = '0, snap_btn  = '0;
  logic [1:0]  exp_conn = '0, snap_conn = '0;

  always @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      have = 1'b0; timer = 0;
      exp_latch = 1'b0; exp_pulse = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
      exp_btn = '0; exp_conn = '0;
    end else begin
      m_off   = cyc - t0;
      m_idle  = !have || (m_off >= L8 + 2);
      m_trig  = bus.enable && (timer == PD - 1);
      m_start = m_idle && (bus.poll_now || m_trig);
      if (!bus.enable || m_start || m_trig) timer = 0;
      else                                  timer++;
      if (m_start) begin
        have = 1'b1;
        t0   = cyc;
        for (int p = 0; p < NP; p++) snap_btn[p*B8 +: B8] = present8[p] ? press8[p] : '0;
        snap_conn = present8;
      end
      cyc++;
      m_off     = cyc - t0;
      exp_latch = have && m_off >= 1 && m_off <= 2*H;
      exp_pulse = have && m_off > 2*H && m_off <= L8 && (((m_off - 2*H - 1) / H) % 2 == 0);
      exp_busy  = have && m_off >= 1 && m_off <= L8;
      exp_valid = have && m_off == L8 + 1;
      if (exp_valid) begin
        exp_btn  = snap_btn;
        exp_conn = snap_conn;
      end
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge sysclk) begin
    if (cmp_on) begin
      chk("latch",     32'(bus.nes_latch), 32'({NP{exp_latch}}));
      chk("pulse",     32'(bus.nes_pulse), 32'({NP{exp_pulse}}));
      chk("busy",      32'(bus.busy),      32'(exp_busy));
      chk("valid",     32'(bus.valid),     32'(exp_valid));
      chk("buttons",   32'(bus.buttons),   32'(exp_btn));
      chk("connected", 32'(bus.connected), 32'(exp_conn));
    end
  end

  int   rises[$];
  int   nvalid = 0;
  logic lq     = 1'b0;
  always @(negedge sysclk) begin
    if (bus.nes_latch[0] && !lq) rises.push_back(cyc);
    lq = bus.nes_latch[0];
    if (bus.valid) nvalid++;
  end

  int ts;

  task automatic poll8_and_wait(input logic [15:0] btn, input logic [1:0] conn, input string tag);
    @(negedge sysclk);
    bus.poll_now = 1'b1;
    ts = cyc;
    @(negedge sysclk);
    bus.poll_now = 1'b0;
    repeat (L8 - 1) @(negedge sysclk);
    chk({tag, "_valid_early"}, 32'(bus.valid), 32'd0);
    @(negedge sysclk);
    chk({tag, "_valid_t73"},   32'(bus.valid), 32'd1);
    chk({tag, "_latency"},     32'(cyc - ts),  32'd73);
    chk({tag, "_buttons"},     32'(bus.buttons), 32'(btn));
    chk({tag, "_connected"},   32'(bus.connected), 32'(conn));
  endtask

  initial begin
    bus.enable = 1'b0; bus.poll_now = 1'b0;
    sbus.enable = 1'b0; sbus.poll_now = 1'b0;
    for (int p = 0; p < NP; p++) begin
      press8[p]  = '0;
      press16[p] = '0;
    end

    repeat (3) @(negedge sysclk);
    cmp_on = 1'b1;
    chk("rst_latch",   32'(bus.nes_latch), 32'd0);
    chk("rst_pulse",   32'(bus.nes_pulse), 32'd0);
    chk("rst_buttons", 32'(bus.buttons),   32'd0);
    chk("rst_conn",    32'(bus.connected), 32'd0);
    chk("rst_valid",   32'(bus.valid),     32'd0);
    chk("rst_busy",    32'(bus.busy),      32'd0);
    chk("rst_btn16",   sbus.buttons,       32'd0);
    @(negedge sysclk);
    #2 sysreset = 1'b1;

    rises.delete();
    repeat (500) @(negedge sysclk);
    chk("idle_no_latch", 32'(rises.size()), 32'd0);

    press8[0] = 8'h09; press8[1] = 8'h00; present8 = 2'b11;
    poll8_and_wait(16'h0009, 2'b11, "a_start");
    repeat (5) @(negedge sysclk);

    press8[0] = 8'hFF; press8[1] = 8'hA5; present8 = 2'b01;
    poll8_and_wait(16'h00FF, 2'b01, "absent");
    repeat (5) @(negedge sysclk);

    press8[0] = 8'h5A; press8[1] = 8'h81; present8 = 2'b11;
    rises.delete();
    bus.enable = 1'b1;
    for (int i = 0; i < 700; i++) begin
      @(negedge sysclk);
      bus.poll_now = (rises.size() == 2) && (cyc == rises[1] + 30);
    end
    bus.poll_now = 1'b0;
    bus.enable   = 1'b0;
    chk("auto_rises", 32'(rises.size()), 32'd3);
    for (int k = 1; k < rises.size(); k++) chk("auto_spacing", 32'(rises[k] - rises[k-1]), 32'd200);
    chk("auto_buttons", 32'(bus.buttons), 32'h815A);
    repeat (5) @(negedge sysclk);

    nvalid = 0;
    @(negedge sysclk);
    bus.poll_now = 1'b1;
    ts = cyc;
    @(negedge sysclk);
    bus.poll_now = 1'b0;
    repeat (33) @(negedge sysclk);
    chk("midrst_pulse_hi", 32'(bus.nes_pulse), 32'd3);
    #2 sysreset = 1'b0;
    #1;
    chk("midrst_latch",   32'(bus.nes_latch), 32'd0);
    chk("midrst_pulse",   32'(bus.nes_pulse), 32'd0);
    chk("midrst_busy",    32'(bus.busy),      32'd0);
    chk("midrst_buttons", 32'(bus.buttons),   32'd0);
    repeat (3) @(negedge sysclk);
    #2 sysreset = 1'b1;
    repeat (100) @(negedge sysclk);
    chk("midrst_no_valid", 32'(nvalid),       32'd0);
    chk("midrst_hold",     32'(bus.buttons),  32'd0);

    poll8_and_wait(16'h815A, 2'b11, "recover");
    repeat (5) @(negedge sysclk);

    press16[0] = 16'hF0F0; press16[1] = 16'h1234; present16 = 2'b11;
    @(negedge sysclk);
    sbus.poll_now = 1'b1;
    ts = cyc;
    @(negedge sysclk);
    sbus.poll_now = 1'b0;
    repeat (135) @(negedge sysclk);
    chk("snes_valid_early", 32'(sbus.valid), 32'd0);
    @(negedge sysclk);
    chk("snes_valid_t137",  32'(sbus.valid),     32'd1);
    chk("snes_busy",        32'(sbus.busy),      32'd0);
    chk("snes_buttons",     sbus.buttons,        32'h1234F0F0);
    chk("snes_connected",   32'(sbus.connected), 32'd3);

    repeat (5) @(negedge sysclk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
